// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: upstream entry fields and the
// registered write-back outputs, split by direction.
interface mem_wb_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 6
);
   logic                      in_valid;
   logic [DATA_WIDTH-1:0]     in_alu_result;
   logic [DATA_WIDTH-1:0]     in_mem_data;
   logic [DATA_WIDTH-1:0]     in_pc_link;
   logic [REG_ADDR_WIDTH-1:0] in_rd;
   logic                      in_reg_write;
   logic                      in_wb_sel_mem;
   logic                      in_wb_sel_link;

   logic                      out_valid;
   logic [DATA_WIDTH-1:0]     out_alu_result;
   logic [DATA_WIDTH-1:0]     out_mem_data;
   logic [DATA_WIDTH-1:0]     out_pc_link;
   logic                      out_sel_a;
   logic                      out_sel_b;
   logic [REG_ADDR_WIDTH-1:0] out_rd;
   logic                      out_reg_write;
   logic [31:0]               retired_count;

   modport master (
      output in_valid, in_alu_result, in_mem_data,
      output in_pc_link, in_rd, in_reg_write,
      output in_wb_sel_mem, in_wb_sel_link,
      input  out_valid, out_alu_result, out_mem_data,
      input  out_pc_link, out_sel_a, out_sel_b,
      input  out_rd, out_reg_write, retired_count
   );

   modport slave (
      input  in_valid, in_alu_result, in_mem_data,
      input  in_pc_link, in_rd, in_reg_write,
      input  in_wb_sel_mem, in_wb_sel_link,
      output out_valid, out_alu_result, out_mem_data,
      output out_pc_link, out_sel_a, out_sel_b,
      output out_rd, out_reg_write, retired_count
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall, flush-to-bubble
// and a retired-instruction counter.
module mem_wb_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 6
) (
   input logic      clock,
   input logic      reset,
   input logic      stall,
   input logic      flush,
   mem_wb_stage_if.slave bus
);
   logic                      valid_q, valid_d;
   logic [DATA_WIDTH-1:0]     alu_q, alu_d;
   logic [DATA_WIDTH-1:0]     mem_q, mem_d;
   logic [DATA_WIDTH-1:0]     link_q, link_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                      sel_a_q, sel_a_d;
   logic                      sel_b_q, sel_b_d;
   logic                      rw_q, rw_d;
   logic [31:0]               cnt_q, cnt_d;

   always_comb begin
      valid_d = valid_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      link_d  = link_q;
      rd_d    = rd_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      rw_d    = rw_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         alu_d   = '0;
         mem_d   = '0;
         link_d  = '0;
         rd_d    = '0;
         sel_a_d = 1'b0;
         sel_b_d = 1'b0;
         rw_d    = 1'b0;
      end else if (!stall) begin
         valid_d = bus.in_valid;
         alu_d   = bus.in_alu_result;
         mem_d   = bus.in_mem_data;
         link_d  = bus.in_pc_link;
         rd_d    = bus.in_rd;
         // link wins over mem so the mux never sees both
         sel_a_d = bus.in_wb_sel_link & bus.in_valid;
         sel_b_d = bus.in_wb_sel_mem & ~bus.in_wb_sel_link
                 & bus.in_valid;
         rw_d    = bus.in_reg_write & bus.in_valid
                 & (bus.in_rd != '0);
         if (bus.in_valid) cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         mem_q   <= '0;
         link_q  <= '0;
         rd_q    <= '0;
         sel_a_q <= 1'b0;
         sel_b_q <= 1'b0;
         rw_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         link_q  <= link_d;
         rd_q    <= rd_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         rw_q    <= rw_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.out_valid      = valid_q;
   assign bus.out_alu_result = alu_q;
   assign bus.out_mem_data   = mem_q;
   assign bus.out_pc_link    = link_q;
   assign bus.out_rd         = rd_q;
   assign bus.out_sel_a      = sel_a_q;
   assign bus.out_sel_b      = sel_b_q;
   assign bus.out_reg_write  = rw_q;
   assign bus.retired_count  = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage against
// a rule-level model of the write-back register.
module tb_mem_wb_stage;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic stall = 1'b0;
   logic flush = 1'b0;
   int   vectors = 0;
   int   errs = 0;

   mem_wb_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(6)) bus ();

   mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(6)) dut (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          valid;
      bit [31:0]   alu;
      bit [31:0]   mem;
      bit [31:0]   link;
      bit [5:0]    rd;
      bit          sa;
      bit          sb;
      bit          rw;
      bit [31:0]   cnt;
   } model_t;

   model_t m;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m.valid));
      chk({tag, ".alu"}, bus.out_alu_result, m.alu);
      chk({tag, ".mem"}, bus.out_mem_data, m.mem);
      chk({tag, ".link"}, bus.out_pc_link, m.link);
      chk({tag, ".rd"}, 32'(bus.out_rd), 32'(m.rd));
      chk({tag, ".sel_a"}, 32'(bus.out_sel_a), 32'(m.sa));
      chk({tag, ".sel_b"}, 32'(bus.out_sel_b), 32'(m.sb));
      chk({tag, ".rw"}, 32'(bus.out_reg_write), 32'(m.rw));
      chk({tag, ".cnt"}, bus.retired_count, m.cnt);
   endtask

   task automatic drive(bit v, bit [31:0] a, bit [31:0] d,
                        bit [31:0] l, bit [5:0] rd, bit rw,
                        bit smem, bit slink);
      bus.in_valid       = v;
      bus.in_alu_result  = a;
      bus.in_mem_data    = d;
      bus.in_pc_link     = l;
      bus.in_rd          = rd;
      bus.in_reg_write   = rw;
      bus.in_wb_sel_mem  = smem;
      bus.in_wb_sel_link = slink;
   endtask

   task automatic drive_rand();
      drive(1'($urandom), $urandom, $urandom, $urandom,
            6'($urandom_range(0, 63)), 1'($urandom),
            1'($urandom), 1'($urandom));
   endtask

   // Model: one edge with inputs currently on the bus
   task automatic model_edge();
      if (flush) begin
         m.valid = 0; m.alu = 0; m.mem = 0; m.link = 0;
         m.rd = 0; m.sa = 0; m.sb = 0; m.rw = 0;
      end else if (!stall) begin
         m.valid = bus.in_valid;
         m.alu   = bus.in_alu_result;
         m.mem   = bus.in_mem_data;
         m.link  = bus.in_pc_link;
         m.rd    = bus.in_rd;
         m.sa    = bus.in_valid && bus.in_wb_sel_link;
         m.sb    = bus.in_valid && bus.in_wb_sel_mem
                   && !bus.in_wb_sel_link;
         m.rw    = bus.in_valid && bus.in_reg_write
                   && (bus.in_rd != 0);
         if (bus.in_valid) m.cnt = m.cnt + 1;
      end
   endtask

   task automatic step(string tag, bit st, bit fl);
      stall = st;
      flush = fl;
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clock);
   endtask

   task automatic model_reset();
      m = '{default: 0};
   endtask

   initial begin
      model_reset();
      drive(1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h77,
            6'd9, 1, 1, 1);
      stall = 1; flush = 1;
      #2;
      check_all("reset_async");
      @(negedge clock);
      reset = 0;
      stall = 0; flush = 0;

      // Directed capture
      drive(1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h40,
            6'd5, 1, 1, 0);
      step("capture", 0, 0);
      chk("capture.cnt1", bus.retired_count, 32'd1);
      chk("capture.selb", 32'(bus.out_sel_b), 32'd1);

      // Link beats mem, rd=0 never written
      drive(1, 32'h11, 32'h22, 32'h33, 6'd0, 1, 1, 1);
      step("selprio", 0, 0);
      chk("selprio.rw0", 32'(bus.out_reg_write), 32'd0);

      // Stall three cycles with changing inputs
      drive(1, 32'hCAFE, 32'hF00D, 32'h80, 6'd12, 1, 0, 0);
      step("pre_stall", 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive_rand();
         step("stall", 1, 0);
      end
      chk("stall.hold_alu", bus.out_alu_result, 32'hCAFE);

      // Flush overrides stall
      drive_rand();
      step("stall_flush", 1, 1);

      // Back-to-back captures
      for (int i = 0; i < 4; i++) begin
         drive_rand();
         step("b2b", 0, 0);
      end

      // Async reset mid-stall, away from an edge
      drive_rand();
      stall = 1;
      #2;
      reset = 1;
      model_reset();
      #1;
      check_all("reset_mid");
      @(negedge clock);
      reset = 0;
      stall = 0;
      drive(1, 32'h5, 32'h6, 32'h7, 6'd3, 1, 0, 1);
      step("post_reset", 0, 0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         drive_rand();
         step("rand", ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0));
      end

      // Counter wrap
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      m.cnt = 32'hFFFF_FFFF;
      drive(1, 32'h1, 32'h2, 32'h3, 6'd4, 1, 0, 0);
      step("wrap", 0, 0);
      chk("wrap.zero", bus.retired_count, 32'd0);

      // Invalid capture leaves count alone
      drive(0, 32'h9, 32'h8, 32'h7, 6'd6, 1, 1, 0);
      step("invalid", 0, 0);
      chk("invalid.valid", 32'(bus.out_valid), 32'd0);
      chk("invalid.cnt", bus.retired_count, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errs);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register between the memory-access stage and the write-back stage of the datapath. It captures the three write-back candidates (ALU result, memory read data, PC link value), the destination register and the write-back select bits, then presents them one cycle later to the three-input write-back mux and the register file. Supports stall (hold), flush (bubble insertion) and a 32-bit retired-instruction counter for debug and performance checks.

## Interface
- DATA_WIDTH, 32, width of every data field
- REG_ADDR_WIDTH, 6, destination-register index width (64-entry register file)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold all outputs; no capture
- flush  in  1  replace the captured entry with a bubble
- in_valid  in  1  upstream entry is a real instruction
- in_alu_result  in  DATA_WIDTH  ALU result
- in_mem_data  in  DATA_WIDTH  data-memory read value
- in_pc_link  in  DATA_WIDTH  PC link value for jump-and-link
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_reg_write  in  1  instruction writes the register file
- in_wb_sel_mem  in  1  write back memory data
- in_wb_sel_link  in  1  write back link value (overrides mem)
- out_valid  out  1  registered valid
- out_alu_result, out_mem_data, out_pc_link  out  DATA_WIDTH each  mux inputs A, B, C
- out_sel_a  out  1  mux control A (selects C when 1)
- out_sel_b  out  1  mux control B (selects B when 1 and sel_a is 0)
- out_rd  out  REG_ADDR_WIDTH  registered destination
- out_reg_write  out  1  gated register-file write enable
- retired_count  out  32  count of valid entries captured

## Operation
- Per rising edge, priority: reset > flush > stall > capture.
- Capture (stall=0, flush=0): all data fields and out_rd load from inputs; out_valid <= in_valid.
- out_sel_a <= in_wb_sel_link & in_valid.
- out_sel_b <= in_wb_sel_mem & ~in_wb_sel_link & in_valid (link wins; sel_b never 1 with sel_a).
- out_reg_write <= in_reg_write & in_valid & (in_rd != 0); register 0 never written.
- Flush: out_valid, out_reg_write, out_sel_a, out_sel_b, out_rd and all three data fields <= 0. Flush overrides a simultaneous stall.
- Stall without flush: every register, including retired_count, holds.
- retired_count increments by 1 on each capture with in_valid=1; wraps 0xFFFFFFFF -> 0. Not incremented on flush, stall, or in_valid=0 capture.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: inputs presented before edge N appear on outputs after edge N.
- Reset asynchronous: asserting reset clears all outputs immediately, independent of clock; every output resets to 0.
- Reset deasserted: first capture on the next rising edge.
- Reset asserted mid-stall or mid-flush: outputs go to 0; stall/flush state is not remembered.
- Back-to-back captures sustain one entry per cycle.
- Stall held for K cycles: outputs constant for K cycles, capture resumes on the first edge with stall=0.

## Test plan
- Reset: drive reset=1 with nonzero inputs -> all outputs 0 without a clock edge; retired_count=0.
- Capture: in_valid=1, alu=0x0000_1234, mem=0xDEAD_BEEF, link=0x40, rd=5, reg_write=1, sel_mem=1 -> next cycle out_alu_result=0x1234, out_sel_a=0, out_sel_b=1, out_reg_write=1, out_rd=5, retired_count=1.
- Select priority and rd=0: sel_mem=1, sel_link=1, rd=0, reg_write=1 -> out_sel_a=1, out_sel_b=0, out_reg_write=0.
- Stall then flush: capture entry, assert stall 3 cycles with changing inputs -> outputs and retired_count constant; assert stall=1 and flush=1 together -> out_valid=0, out_reg_write=0, all data 0, count unchanged.
- Counter wrap: preload by 2^32-1 valid captures (or force) -> next valid capture gives retired_count=0; in_valid=0 capture leaves count unchanged and out_valid=0.
